pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the five-stage MIPS core; generalises the fixed D/E register.
- Carries an opaque payload vector plus a valid bit through DEPTH slots.
- Supports stall (hold), bubble insertion, partial-field keep on bubble (PC/BD preservation for CP0 exceptions) and whole-chain kill.
- Keeps saturating stall and flush event counters for performance debug.
- Instantiated between F/D, D/E, E/M and M/W. DEPTH>1 is used for latency balancing around the multi-cycle MDU.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_stage_reg_if.sv | 28 ++
 rtl/pipe_slot.sv | 65 ++++++
 rtl/pipe_stage_reg.sv | 97 +++++++++
 tb/tb_pipe_stage_reg.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the MIPS inter-stage pipeline registers: depth limits, counter width,
// and the payload field offsets each stage uses when building its keep field.
package pipe_pkg;

   localparam int unsigned MAX_DEPTH     = 8;
   localparam int unsigned CNT_W_DEFAULT = 16;

   // Field LSB offsets inside each stage payload; the PC sits lowest so CP0 can keep it.
   localparam int unsigned F2D_PC_LO    = 0;
   localparam int unsigned F2D_INSTR_LO = 32;
   localparam int unsigned D2E_PC_LO    = 0;
   localparam int unsigned D2E_INSTR_LO = 32;
   localparam int unsigned D2E_RS_LO    = 64;
   localparam int unsigned E2M_PC_LO    = 0;
   localparam int unsigned E2M_ALU_LO   = 32;
   localparam int unsigned M2W_PC_LO    = 0;
   localparam int unsigned M2W_RES_LO   = 32;

   typedef enum logic [1:0] {
      SlotHold,
      SlotLoad,
      SlotBubble,
      SlotKill
   } slot_op_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Control, data and counter bundle for one pipe_stage_reg; the stage logic drives the master side.
interface pipe_stage_reg_if #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned CNT_W = 16
) ();

   logic             en;
   logic             flush;
   logic             flush_all;
   logic             in_valid;
   logic [WIDTH-1:0] in_payload;
   logic             cnt_clr;
   logic             out_valid;
   logic [WIDTH-1:0] out_payload;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output en, flush, flush_all, in_valid, in_payload, cnt_clr,
      input  out_valid, out_payload, stall_cnt, flush_cnt
   );

   modport slave (
      input  en, flush, flush_all, in_valid, in_payload, cnt_clr,
      output out_valid, out_payload, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_slot.sv
// One valid+payload register of the pipeline chain. A bubble clears everything except the
// keep field, which is taken from the incoming payload so PC/BD survive for CP0.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH   = 96,
   parameter int unsigned KEEP_LO = 0,
   parameter int unsigned KEEP_W  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  slot_op_e         op_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] payload_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] payload_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] payload_q, payload_d;
   logic [WIDTH-1:0] bubble_payload;

   if (KEEP_W > 0) begin : g_keep
      always_comb begin
         bubble_payload = '0;
         bubble_payload[KEEP_LO +: KEEP_W] = payload_i[KEEP_LO +: KEEP_W];
      end
   end else begin : g_no_keep
      assign bubble_payload = '0;
   end

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      unique case (op_i)
         SlotLoad: begin
            valid_d   = valid_i;
            payload_d = payload_i;
         end
         SlotBubble: begin
            valid_d   = 1'b0;
            payload_d = bubble_payload;
         end
         SlotKill: begin
            valid_d   = 1'b0;
            payload_d = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign valid_o   = valid_q;
   assign payload_o = payload_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots with stall, bubble, keep-on-bubble and
// whole-chain kill, plus saturating stall/flush event counters for performance debug.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH   = 96,
   parameter int unsigned DEPTH   = 1,
   parameter int unsigned KEEP_LO = 0,
   parameter int unsigned KEEP_W  = 32,
   parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
   input logic              clk,
   input logic              reset,
   pipe_stage_reg_if.slave  bus
);

   logic             slot_valid   [DEPTH];
   logic [WIDTH-1:0] slot_payload [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      slot_op_e op;
      if (i == 0) begin : g_head
         // Flush bubbles the head even while stalled: upstream holds, a nop enters here.
         assign op = bus.flush_all ? SlotKill   :
                     bus.flush     ? SlotBubble :
                     bus.en        ? SlotLoad   : SlotHold;

         pipe_slot #(
            .WIDTH   (WIDTH),
            .KEEP_LO (KEEP_LO),
            .KEEP_W  (KEEP_W)
         ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .op_i      (op),
            .valid_i   (bus.in_valid),
            .payload_i (bus.in_payload),
            .valid_o   (slot_valid[i]),
            .payload_o (slot_payload[i])
         );
      end else begin : g_tail
         assign op = bus.flush_all ? SlotKill :
                     bus.en        ? SlotLoad : SlotHold;

         pipe_slot #(
            .WIDTH   (WIDTH),
            .KEEP_LO (KEEP_LO),
            .KEEP_W  (KEEP_W)
         ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .op_i      (op),
            .valid_i   (slot_valid[i-1]),
            .payload_i (slot_payload[i-1]),
            .valid_o   (slot_valid[i]),
            .payload_o (slot_payload[i])
         );
      end
   end

   assign bus.out_valid   = slot_valid[DEPTH-1];
   assign bus.out_payload = slot_payload[DEPTH-1];

   logic             stall_ev, flush_ev;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   assign stall_ev = !bus.en && !bus.flush && !bus.flush_all;
   assign flush_ev = bus.flush || bus.flush_all;

   // Counters saturate rather than wrap; clear takes precedence over a same-cycle event.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a DEPTH=1 instance with a 32-bit keep field and a DEPTH=3
// instance with no keep field and 4-bit counters.
module tb_pipe_stage_reg;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.WIDTH(96), .CNT_W(16)) a_if ();
   pipe_stage_reg_if #(.WIDTH(16), .CNT_W(4))  b_if ();

   pipe_stage_reg #(
      .WIDTH(96), .DEPTH(1), .KEEP_LO(0), .KEEP_W(32), .CNT_W(16)
   ) u_a (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   pipe_stage_reg #(
      .WIDTH(16), .DEPTH(3), .KEEP_LO(0), .KEEP_W(0), .CNT_W(4)
   ) u_b (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   localparam logic [95:0] P1 = 96'h1111_2222_3333_4444_5555_ABCD;
   localparam logic [95:0] P2 = 96'h0F0F_0F0F_0000_0000_1234_5678;
   localparam logic [95:0] P3 = 96'hAAAA_5555_AAAA_5555_AAAA_5555;
   localparam logic [95:0] P4 = 96'h0000_0001_0000_0002_0000_0003;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      a_if.en = 1'b0; a_if.flush = 1'b0; a_if.flush_all = 1'b0;
      a_if.in_valid = 1'b0; a_if.in_payload = '0; a_if.cnt_clr = 1'b0;
      b_if.en = 1'b0; b_if.flush = 1'b0; b_if.flush_all = 1'b0;
      b_if.in_valid = 1'b0; b_if.in_payload = '0; b_if.cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_all();
      repeat (2) tick();
      total++; if (a_if.out_valid !== 1'b0) begin bad++;
         $display("FAIL reset_a_valid got=%b want=0", a_if.out_valid); end
      total++; if (a_if.out_payload !== 96'h0) begin bad++;
         $display("FAIL reset_a_payload got=%h want=0", a_if.out_payload); end
      total++; if (a_if.stall_cnt !== 16'd0) begin bad++;
         $display("FAIL reset_a_stall got=%0d want=0", a_if.stall_cnt); end
      total++; if (a_if.flush_cnt !== 16'd0) begin bad++;
         $display("FAIL reset_a_flush got=%0d want=0", a_if.flush_cnt); end
      total++; if (b_if.out_valid !== 1'b0) begin bad++;
         $display("FAIL reset_b_valid got=%b want=0", b_if.out_valid); end
      total++; if (b_if.stall_cnt !== 4'd0) begin bad++;
         $display("FAIL reset_b_stall got=%0d want=0", b_if.stall_cnt); end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      a_if.cnt_clr = 1'b1; a_if.en = 1'b1; a_if.in_valid = 1'b0; a_if.in_payload = '0;
      tick();
      a_if.cnt_clr = 1'b0;
      a_if.in_valid = 1'b1; a_if.in_payload = P1;
      #2;
      total++; if (a_if.out_valid !== 1'b0) begin bad++;
         $display("FAIL basic_no_comb_path got=%b want=0", a_if.out_valid); end
      tick();
      total++; if (a_if.out_valid !== 1'b1) begin bad++;
         $display("FAIL basic_valid got=%b want=1", a_if.out_valid); end
      total++; if (a_if.out_payload !== P1) begin bad++;
         $display("FAIL basic_payload got=%h want=%h", a_if.out_payload, P1); end
      total++; if (a_if.stall_cnt !== 16'd0) begin bad++;
         $display("FAIL basic_stall got=%0d want=0", a_if.stall_cnt); end
      a_if.in_valid = 1'b0; a_if.in_payload = P2;
      tick();
      total++; if (a_if.out_valid !== 1'b0 || a_if.out_payload !== P2) begin bad++;
         $display("FAIL basic_invalid_pass got=%b/%h want=0/%h",
                  a_if.out_valid, a_if.out_payload, P2); end
   endtask

   task automatic test_stall_bubble();
      a_if.en = 1'b1; a_if.in_valid = 1'b1; a_if.in_payload = P1; a_if.cnt_clr = 1'b1;
      tick();
      a_if.cnt_clr = 1'b0;
      a_if.en = 1'b0; a_if.flush = 1'b1;
      a_if.in_payload = {64'hDEAD_BEEF_CAFE_F00D, 32'h0000_3008};
      tick();
      a_if.flush = 1'b0;
      total++; if (a_if.out_valid !== 1'b0) begin bad++;
         $display("FAIL bubble_valid got=%b want=0", a_if.out_valid); end
      total++; if (a_if.out_payload !== 96'h3008) begin bad++;
         $display("FAIL bubble_keep got=%h want=%h", a_if.out_payload, 96'h3008); end
      total++; if (a_if.flush_cnt !== 16'd1 || a_if.stall_cnt !== 16'd0) begin bad++;
         $display("FAIL bubble_cnts got=%0d/%0d want=1/0", a_if.flush_cnt, a_if.stall_cnt); end
      // Kill must also wipe the keep field.
      a_if.en = 1'b1; a_if.in_payload = P1;
      tick();
      a_if.flush = 1'b1; a_if.flush_all = 1'b1;
      tick();
      a_if.flush = 1'b0; a_if.flush_all = 1'b0; a_if.en = 1'b0;
      total++; if (a_if.out_valid !== 1'b0 || a_if.out_payload !== 96'h0) begin bad++;
         $display("FAIL kill_a got=%b/%h want=0/0", a_if.out_valid, a_if.out_payload); end
      total++; if (a_if.flush_cnt !== 16'd2) begin bad++;
         $display("FAIL kill_a_cnt got=%0d want=2", a_if.flush_cnt); end
   endtask

   task automatic test_hold();
      b_if.en = 1'b1; b_if.in_valid = 1'b0; b_if.in_payload = '0; b_if.cnt_clr = 1'b1;
      tick();
      b_if.cnt_clr = 1'b0; b_if.in_valid = 1'b1;
      b_if.in_payload = 16'hA001; tick();
      b_if.in_payload = 16'hB002; tick();
      total++; if (b_if.out_valid !== 1'b0) begin bad++;
         $display("FAIL hold_latency got=%b want=0", b_if.out_valid); end
      b_if.in_payload = 16'hC003; tick();
      total++; if (b_if.out_valid !== 1'b1 || b_if.out_payload !== 16'hA001) begin bad++;
         $display("FAIL hold_fill got=%b/%h want=1/a001", b_if.out_valid, b_if.out_payload); end
      b_if.en = 1'b0; b_if.in_payload = 16'hD004;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++; if (b_if.out_payload !== 16'hA001) begin bad++;
            $display("FAIL hold_keep[%0d] got=%h want=a001", k, b_if.out_payload); end
      end
      total++; if (b_if.stall_cnt !== 4'd5) begin bad++;
         $display("FAIL hold_stall_cnt got=%0d want=5", b_if.stall_cnt); end
      b_if.en = 1'b1;
      tick();
      total++; if (b_if.out_payload !== 16'hB002) begin bad++;
         $display("FAIL hold_resume_b got=%h want=b002", b_if.out_payload); end
      tick();
      total++; if (b_if.out_payload !== 16'hC003) begin bad++;
         $display("FAIL hold_resume_c got=%h want=c003", b_if.out_payload); end
      tick();
      total++; if (b_if.out_payload !== 16'hD004 || b_if.stall_cnt !== 4'd5) begin bad++;
         $display("FAIL hold_resume_d got=%h/%0d want=d004/5", b_if.out_payload,
                  b_if.stall_cnt); end
   endtask

   task automatic test_flush_all();
      b_if.en = 1'b1; b_if.in_valid = 1'b1; b_if.cnt_clr = 1'b1;
      b_if.in_payload = 16'hE001; tick();
      b_if.cnt_clr = 1'b0;
      b_if.in_payload = 16'hE002; tick();
      b_if.in_payload = 16'hE003; tick();
      b_if.en = 1'b0; b_if.flush_all = 1'b1; b_if.in_payload = 16'hF00F;
      tick();
      b_if.flush_all = 1'b0;
      total++; if (b_if.out_valid !== 1'b0 || b_if.out_payload !== 16'h0) begin bad++;
         $display("FAIL kill_b got=%b/%h want=0/0", b_if.out_valid, b_if.out_payload); end
      total++; if (b_if.flush_cnt !== 4'd1 || b_if.stall_cnt !== 4'd0) begin bad++;
         $display("FAIL kill_b_cnts got=%0d/%0d want=1/0", b_if.flush_cnt, b_if.stall_cnt); end
      b_if.en = 1'b1; b_if.in_payload = 16'h7777;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++; if (b_if.out_valid !== 1'b0 || b_if.out_payload !== 16'h0) begin bad++;
            $display("FAIL kill_b_drain[%0d] got=%b/%h want=0/0", k, b_if.out_valid,
                     b_if.out_payload); end
      end
      tick();
      total++; if (b_if.out_valid !== 1'b1 || b_if.out_payload !== 16'h7777) begin bad++;
         $display("FAIL kill_b_new got=%b/%h want=1/7777", b_if.out_valid, b_if.out_payload); end
   endtask

   task automatic test_flush_shift();
      b_if.en = 1'b1; b_if.in_valid = 1'b1; b_if.cnt_clr = 1'b1;
      b_if.in_payload = 16'h1001; tick();
      b_if.cnt_clr = 1'b0;
      b_if.in_payload = 16'h1002; tick();
      b_if.in_payload = 16'h1003; tick();
      b_if.en = 1'b0; b_if.flush = 1'b1; b_if.in_payload = 16'h2222;
      tick();
      total++; if (b_if.out_valid !== 1'b1 || b_if.out_payload !== 16'h1001) begin bad++;
         $display("FAIL flush_tail_hold got=%b/%h want=1/1001", b_if.out_valid,
                  b_if.out_payload); end
      b_if.en = 1'b1;
      tick();
      total++; if (b_if.out_valid !== 1'b1 || b_if.out_payload !== 16'h1002) begin bad++;
         $display("FAIL flush_tail_shift got=%b/%h want=1/1002", b_if.out_valid,
                  b_if.out_payload); end
      b_if.flush = 1'b0;
      tick();
      total++; if (b_if.out_valid !== 1'b0 || b_if.out_payload !== 16'h0) begin bad++;
         $display("FAIL flush_nokeep got=%b/%h want=0/0", b_if.out_valid, b_if.out_payload); end
      total++; if (b_if.flush_cnt !== 4'd2 || b_if.stall_cnt !== 4'd0) begin bad++;
         $display("FAIL flush_cnts got=%0d/%0d want=2/0", b_if.flush_cnt, b_if.stall_cnt); end
   endtask

   task automatic test_saturation();
      b_if.en = 1'b0; b_if.in_valid = 1'b0; b_if.cnt_clr = 1'b1;
      tick();
      b_if.cnt_clr = 1'b0;
      total++; if (b_if.stall_cnt !== 4'd0) begin bad++;
         $display("FAIL sat_clr_first got=%0d want=0", b_if.stall_cnt); end
      repeat (20) tick();
      total++; if (b_if.stall_cnt !== 4'd15) begin bad++;
         $display("FAIL sat_stall got=%0d want=15", b_if.stall_cnt); end
      b_if.cnt_clr = 1'b1;
      tick();
      b_if.cnt_clr = 1'b0;
      total++; if (b_if.stall_cnt !== 4'd0) begin bad++;
         $display("FAIL sat_clr_beats_inc got=%0d want=0", b_if.stall_cnt); end
      tick();
      total++; if (b_if.stall_cnt !== 4'd1) begin bad++;
         $display("FAIL sat_restart got=%0d want=1", b_if.stall_cnt); end
      b_if.flush = 1'b1;
      repeat (20) tick();
      b_if.flush = 1'b0;
      total++; if (b_if.flush_cnt !== 4'd15 || b_if.stall_cnt !== 4'd1) begin bad++;
         $display("FAIL sat_flush got=%0d/%0d want=15/1", b_if.flush_cnt, b_if.stall_cnt); end
   endtask

   task automatic test_async_reset();
      a_if.en = 1'b1; a_if.in_valid = 1'b1; a_if.in_payload = P3;
      tick();
      total++; if (a_if.out_valid !== 1'b1 || a_if.out_payload !== P3) begin bad++;
         $display("FAIL areset_pre got=%b/%h want=1/%h", a_if.out_valid, a_if.out_payload, P3); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (a_if.out_valid !== 1'b0 || a_if.out_payload !== 96'h0) begin bad++;
         $display("FAIL areset_out got=%b/%h want=0/0", a_if.out_valid, a_if.out_payload); end
      total++; if (a_if.stall_cnt !== 16'd0 || a_if.flush_cnt !== 16'd0) begin bad++;
         $display("FAIL areset_cnts got=%0d/%0d want=0/0", a_if.stall_cnt, a_if.flush_cnt); end
      total++; if (b_if.stall_cnt !== 4'd0 || b_if.flush_cnt !== 4'd0) begin bad++;
         $display("FAIL areset_b_cnts got=%0d/%0d want=0/0", b_if.stall_cnt, b_if.flush_cnt); end
      @(negedge clk);
      reset = 1'b1;
      a_if.in_payload = P4;
      tick();
      total++; if (a_if.out_valid !== 1'b1 || a_if.out_payload !== P4) begin bad++;
         $display("FAIL areset_post got=%b/%h want=1/%h", a_if.out_valid, a_if.out_payload, P4); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_bubble();
      idle_all();
      test_hold();
      test_flush_all();
      test_flush_shift();
      test_saturation();
      idle_all();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
